// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the 8-bit pipelined core. It sits directly
// upstream of decode. It owns the program counter and drives the
// instruction-memory address. It also holds the IF/ID pipeline register.
//
// Vector loads:
//   - After reset, the boot PC is loaded from M[RST_VEC_ADDR].
//   - On interrupt entry, the ISR PC is loaded from M[INT_VEC_ADDR].
//
// Ports:
//   clk            - core clock, rising edge
//   rst            - asynchronous, active-low reset
//   PC_Write_En    - 1 = PC may advance
//   IF_ID_Write_En - 1 = IF/ID instruction loads
//                    0 = hold the instruction and capture the immediate byte
//   Inject_Bubble  - load NOP into IF/ID (only when IF_ID_Write_En=1)
//   Inject_Int     - begin interrupt entry
//   branch_taken   - execute-stage redirect
//   branch_target  - redirect address
//   imem_data      - instruction memory read data (combinational read)
//   imem_addr      - instruction memory address
//   if_id_instr    - instruction presented to decode
//   if_id_imm      - immediate byte for two-byte instructions
//   if_id_pc_plus1 - address following the instruction held in IF/ID
//   if_id_valid    - 1 = if_id_instr is a real fetched instruction
//   int_ret_pc     - return address saved at interrupt entry
//   boot_done      - 1 once the boot vector has been loaded
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter int                 PC_W         = 8,
  parameter int                 INSTR_W      = 8,
  parameter logic [INSTR_W-1:0] NOP_INSTR    = 8'h00,
  parameter logic [PC_W-1:0]    RST_VEC_ADDR = 8'h00,
  parameter logic [PC_W-1:0]    INT_VEC_ADDR = 8'h01
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               PC_Write_En,
  input  logic               IF_ID_Write_En,
  input  logic               Inject_Bubble,
  input  logic               Inject_Int,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [PC_W-1:0]    imem_addr,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [INSTR_W-1:0] if_id_imm,
  output logic [PC_W-1:0]    if_id_pc_plus1,
  output logic               if_id_valid,
  output logic [PC_W-1:0]    int_ret_pc,
  output logic               boot_done
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_VEC  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
  logic [INSTR_W-1:0] if_id_imm_q, if_id_imm_d;
  logic [PC_W-1:0]    if_id_pc_plus1_q, if_id_pc_plus1_d;
  logic               if_id_valid_q, if_id_valid_d;
  logic [PC_W-1:0]    int_ret_pc_q, int_ret_pc_d;
  logic               boot_done_q, boot_done_d;

  // The sum naturally wraps modulo 2^PC_W, so 8'hFF is followed by 8'h00.
  logic [PC_W-1:0]    pc_plus1;

  assign pc_plus1 = pc_q + PC_W'(1);

  // Next-state, address mux and IF/ID update.
  // Vector loads reuse the single memory port: the address is switched to
  // the vector slot, and the read data goes straight into the PC.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    if_id_instr_d    = if_id_instr_q;
    if_id_imm_d      = if_id_imm_q;
    if_id_pc_plus1_d = if_id_pc_plus1_q;
    if_id_valid_d    = if_id_valid_q;
    int_ret_pc_d     = int_ret_pc_q;
    boot_done_d      = boot_done_q;
    imem_addr        = pc_q;

    case (state_q)
      S_BOOT: begin
        imem_addr     = RST_VEC_ADDR;
        pc_d          = PC_W'(imem_data);
        boot_done_d   = 1'b1;
        if_id_instr_d = NOP_INSTR;
        if_id_valid_d = 1'b0;
        state_d       = S_RUN;
      end

      S_RUN: begin
        imem_addr = pc_q;
        if (branch_taken) begin
          // A redirect wins over everything. A coincident interrupt request
          // is dropped here; control keeps it asserted until it is taken.
          pc_d          = branch_target;
          if_id_instr_d = NOP_INSTR;
          if_id_valid_d = 1'b0;
        end else if (Inject_Int) begin
          // The fetch at pc_q is abandoned. pc_q is therefore the address
          // to return to after the ISR.
          int_ret_pc_d  = pc_q;
          if_id_instr_d = NOP_INSTR;
          if_id_valid_d = 1'b0;
          state_d       = S_VEC;
        end else begin
          if (PC_Write_En) begin
            pc_d = pc_plus1;
          end
          if (IF_ID_Write_En) begin
            if_id_pc_plus1_d = pc_plus1;
            if (Inject_Bubble) begin
              if_id_instr_d = NOP_INSTR;
              if_id_valid_d = 1'b0;
            end else begin
              if_id_instr_d = imem_data;
              if_id_valid_d = 1'b1;
            end
          end else begin
            // The instruction is frozen in IF/ID. The byte now on the bus is
            // the immediate operand that follows it.
            if_id_imm_d = imem_data;
          end
        end
      end

      S_VEC: begin
        imem_addr     = INT_VEC_ADDR;
        pc_d          = PC_W'(imem_data);
        if_id_instr_d = NOP_INSTR;
        if_id_valid_d = 1'b0;
        state_d       = S_RUN;
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  // State and pipeline registers.
  // All registers clear as soon as rst falls, whatever state the stage is in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= S_BOOT;
      pc_q             <= '0;
      if_id_instr_q    <= NOP_INSTR;
      if_id_imm_q      <= '0;
      if_id_pc_plus1_q <= '0;
      if_id_valid_q    <= 1'b0;
      int_ret_pc_q     <= '0;
      boot_done_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      if_id_instr_q    <= if_id_instr_d;
      if_id_imm_q      <= if_id_imm_d;
      if_id_pc_plus1_q <= if_id_pc_plus1_d;
      if_id_valid_q    <= if_id_valid_d;
      int_ret_pc_q     <= int_ret_pc_d;
      boot_done_q      <= boot_done_d;
    end
  end

  assign if_id_instr    = if_id_instr_q;
  assign if_id_imm      = if_id_imm_q;
  assign if_id_pc_plus1 = if_id_pc_plus1_q;
  assign if_id_valid    = if_id_valid_q;
  assign int_ret_pc     = int_ret_pc_q;
  assign boot_done      = boot_done_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage.
// The instruction memory is modelled as a combinational array.
// Every expected value below is a hand-computed constant.
module tb_fetch_stage;

  logic       clk;
  logic       rst;
  logic       PC_Write_En;
  logic       IF_ID_Write_En;
  logic       Inject_Bubble;
  logic       Inject_Int;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic [7:0] imem_data;
  logic [7:0] imem_addr;
  logic [7:0] if_id_instr;
  logic [7:0] if_id_imm;
  logic [7:0] if_id_pc_plus1;
  logic       if_id_valid;
  logic [7:0] int_ret_pc;
  logic       boot_done;

  logic [7:0] mem [256];

  int vectorCount;
  int miscompareCount;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .PC_Write_En    (PC_Write_En),
    .IF_ID_Write_En (IF_ID_Write_En),
    .Inject_Bubble  (Inject_Bubble),
    .Inject_Int     (Inject_Int),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .imem_data      (imem_data),
    .imem_addr      (imem_addr),
    .if_id_instr    (if_id_instr),
    .if_id_imm      (if_id_imm),
    .if_id_pc_plus1 (if_id_pc_plus1),
    .if_id_valid    (if_id_valid),
    .int_ret_pc     (int_ret_pc),
    .boot_done      (boot_done)
  );

  // Combinational instruction memory
  assign imem_data = mem[imem_addr];

  // 10 ns clock period, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expected value.
  // The comparison is counted, and a mismatch is reported.
  task automatic checkOutput(input string tag, input logic [7:0] actual,
                             input logic [7:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: got 8'h%h, expected 8'h%h", tag, actual, expected);
    end
  endtask

  // Drive the control inputs for the next clock edge.
  task automatic applyStimulus(input logic pcWe, input logic ifIdWe,
                               input logic bubble, input logic intr,
                               input logic br, input logic [7:0] target);
    PC_Write_En    = pcWe;
    IF_ID_Write_En = ifIdWe;
    Inject_Bubble  = bubble;
    Inject_Int     = intr;
    branch_taken   = br;
    branch_target  = target;
  endtask

  // Advance one clock. Outputs are sampled 1 ns after the rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Run normally: PC and IF/ID both advance, no bubble, interrupt or branch.
  task automatic runNormal();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    vectorCount     = 0;
    miscompareCount = 0;

    for (int i = 0; i < 256; i++) mem[i] = 8'h0F;
    mem[8'h00] = 8'h10;
    mem[8'h01] = 8'hE0;
    mem[8'h10] = 8'h21;
    mem[8'h20] = 8'hC4;
    mem[8'h21] = 8'h5A;
    mem[8'h30] = 8'h71;
    mem[8'h42] = 8'h99;
    mem[8'h80] = 8'h66;
    mem[8'hE0] = 8'hE5;
    mem[8'hFE] = 8'hF1;
    mem[8'hFF] = 8'hF2;

    // ---------------- Reset values ----------------
    rst = 1'b0;
    runNormal();
    #2;
    checkOutput("rst_addr",      imem_addr,      8'h00);
    checkOutput("rst_instr",     if_id_instr,    8'h00);
    checkOutput("rst_imm",       if_id_imm,      8'h00);
    checkOutput("rst_pcp1",      if_id_pc_plus1, 8'h00);
    checkOutput("rst_valid",     {7'd0, if_id_valid}, 8'h00);
    checkOutput("rst_intret",    int_ret_pc,     8'h00);
    checkOutput("rst_bootdone",  {7'd0, boot_done},   8'h00);

    // ---------------- Test 1: boot ----------------
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("boot_addr_vec", imem_addr, 8'h00);
    stepCycle();
    checkOutput("boot_pc",       imem_addr, 8'h10);
    checkOutput("boot_done",     {7'd0, boot_done},   8'h01);
    checkOutput("boot_valid",    {7'd0, if_id_valid}, 8'h00);
    stepCycle();
    checkOutput("boot_instr",    if_id_instr,    8'h21);
    checkOutput("boot_valid2",   {7'd0, if_id_valid}, 8'h01);
    checkOutput("boot_pcp1",     if_id_pc_plus1, 8'h11);
    checkOutput("boot_addr2",    imem_addr,      8'h11);

    // ---------------- Test 2: PC wrap ----------------
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFE);
    stepCycle();
    checkOutput("wrap_addr_fe",  imem_addr,   8'hFE);
    checkOutput("wrap_flush",    if_id_instr, 8'h00);
    checkOutput("wrap_flush_v",  {7'd0, if_id_valid}, 8'h00);
    runNormal();
    stepCycle();
    checkOutput("wrap_addr_ff",  imem_addr,      8'hFF);
    checkOutput("wrap_instr_fe", if_id_instr,    8'hF1);
    checkOutput("wrap_pcp1_ff",  if_id_pc_plus1, 8'hFF);
    stepCycle();
    checkOutput("wrap_addr_00",  imem_addr,      8'h00);
    checkOutput("wrap_instr_ff", if_id_instr,    8'hF2);
    checkOutput("wrap_pcp1_00",  if_id_pc_plus1, 8'h00);
    stepCycle();
    checkOutput("wrap_instr_00", if_id_instr,    8'h10);
    checkOutput("wrap_addr_01",  imem_addr,      8'h01);

    // ---------------- Test 3: LDM immediate capture ----------------
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h20);
    stepCycle();
    checkOutput("ldm_addr20",    imem_addr,   8'h20);
    runNormal();
    stepCycle();
    checkOutput("ldm_instr",     if_id_instr, 8'hC4);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    stepCycle();
    checkOutput("ldm_hold",      if_id_instr, 8'hC4);
    checkOutput("ldm_imm",       if_id_imm,   8'h5A);
    checkOutput("ldm_pc22",      imem_addr,   8'h22);
    checkOutput("ldm_valid",     {7'd0, if_id_valid}, 8'h01);
    // A bubble with the IF/ID write enabled inserts a NOP.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    stepCycle();
    checkOutput("bub_instr",     if_id_instr,    8'h00);
    checkOutput("bub_valid",     {7'd0, if_id_valid}, 8'h00);
    checkOutput("bub_pcp1",      if_id_pc_plus1, 8'h23);
    checkOutput("bub_imm_kept",  if_id_imm,      8'h5A);

    // ---------------- Test 4: stall ----------------
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h30);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("stall_addr",  imem_addr,   8'h30);
      checkOutput("stall_instr", if_id_instr, 8'h00);
    end
    checkOutput("stall_imm",     if_id_imm,   8'h71);
    runNormal();
    stepCycle();
    checkOutput("resume_instr",  if_id_instr,    8'h71);
    checkOutput("resume_pcp1",   if_id_pc_plus1, 8'h31);
    checkOutput("resume_addr",   imem_addr,      8'h31);

    // ---------------- Test 5: branch beats interrupt ----------------
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h80);
    stepCycle();
    checkOutput("brint_addr",    imem_addr,   8'h80);
    checkOutput("brint_instr",   if_id_instr, 8'h00);
    checkOutput("brint_valid",   {7'd0, if_id_valid}, 8'h00);
    checkOutput("brint_intret",  int_ret_pc,  8'h00);
    runNormal();
    stepCycle();
    checkOutput("brint_run",     imem_addr,   8'h81);
    checkOutput("brint_instr2",  if_id_instr, 8'h66);

    // ---------------- Test 6: interrupt entry ----------------
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h42);
    stepCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    stepCycle();
    checkOutput("int_retpc",     int_ret_pc,  8'h42);
    checkOutput("int_vecaddr",   imem_addr,   8'h01);
    checkOutput("int_nop1",      if_id_instr, 8'h00);
    runNormal();
    stepCycle();
    checkOutput("int_isr_pc",    imem_addr,   8'hE0);
    checkOutput("int_nop2",      if_id_instr, 8'h00);
    checkOutput("int_valid2",    {7'd0, if_id_valid}, 8'h00);
    stepCycle();
    checkOutput("int_isr_instr", if_id_instr,    8'hE5);
    checkOutput("int_isr_pcp1",  if_id_pc_plus1, 8'hE1);

    // Reset asserted while the stage is in S_VEC
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    stepCycle();
    checkOutput("int2_vecaddr",  imem_addr,  8'h01);
    checkOutput("int2_retpc",    int_ret_pc, 8'hE1);
    runNormal();
    #2;
    rst = 1'b0;
    #1;
    checkOutput("mrst_addr",     imem_addr,  8'h00);
    checkOutput("mrst_boot",     {7'd0, boot_done},   8'h00);
    checkOutput("mrst_intret",   int_ret_pc, 8'h00);
    checkOutput("mrst_imm",      if_id_imm,  8'h00);
    checkOutput("mrst_instr",    if_id_instr, 8'h00);
    checkOutput("mrst_valid",    {7'd0, if_id_valid}, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    stepCycle();
    checkOutput("reboot_pc",     imem_addr, 8'h10);
    checkOutput("reboot_done",   {7'd0, boot_done}, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the 8-bit pipelined core, directly upstream of Control_unit/decode. It owns the PC, drives the instruction-memory address and holds the IF/ID pipeline register. It performs the boot vector load from M[0] and the interrupt vector load from M[1], and applies PC_Write_En, IF_ID_Write_En, Inject_Bubble and Inject_Int from the control unit, plus branch redirects from execute.

Parameters:
PC_W, 8, PC / instruction-memory address width
INSTR_W, 8, instruction and immediate byte width
NOP_INSTR, 8'h00, encoding loaded into IF/ID on a bubble or flush
RST_VEC_ADDR, 8'h00, memory address holding the boot PC
INT_VEC_ADDR, 8'h01, memory address holding the ISR PC

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-low reset
PC_Write_En  in  1  1 = PC may advance
IF_ID_Write_En  in  1  1 = IF/ID instruction loads; 0 = hold instruction, capture immediate
Inject_Bubble  in  1  load NOP into IF/ID (only honoured when IF_ID_Write_En=1)
Inject_Int  in  1  begin interrupt entry
branch_taken  in  1  execute-stage redirect
branch_target  in  PC_W  redirect address
imem_data  in  INSTR_W  instruction memory read data (combinational read)
imem_addr  out  PC_W  instruction memory address
if_id_instr  out  INSTR_W  instruction presented to decode (opcode=[7:4], ra=[3:2], rb=[1:0])
if_id_imm  out  INSTR_W  immediate byte for two-byte instructions
if_id_pc_plus1  out  PC_W  address following the instruction in IF/ID
if_id_valid  out  1  1 = if_id_instr is a real fetched instruction
int_ret_pc  out  PC_W  return address saved at interrupt entry, consumed by the push path
boot_done  out  1  1 once the boot vector has been loaded

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-low: every register clears immediately on the falling edge of rst.
- Reset values: PC=0, state=S_BOOT, if_id_instr=NOP_INSTR, if_id_imm=0, if_id_pc_plus1=0, if_id_valid=0, int_ret_pc=0, boot_done=0.
- Address mux (combinational):
  - S_BOOT: imem_addr=RST_VEC_ADDR.
  - S_VEC: imem_addr=INT_VEC_ADDR.
  - S_RUN: imem_addr=PC.
- State machine: S_BOOT, S_RUN, S_VEC.
- S_BOOT (first edge after rst released):
  - PC<=imem_data; boot_done<=1; IF/ID<=NOP, valid=0; go to S_RUN.
  - All control inputs and branch_taken are ignored.
- S_RUN, priority order (first match wins):
  1. branch_taken: PC<=branch_target. IF/ID<=NOP, valid=0 (flush). Overrides stall, bubble and Inject_Int. Inject_Int is dropped this cycle; control re-asserts it.
  2. Inject_Int: int_ret_pc<=PC (the fetch in progress is discarded). IF/ID<=NOP, valid=0. PC unchanged. Go to S_VEC.
  3. Otherwise:
     - PC: PC<=PC+1 if PC_Write_En, else hold. Increment is modulo 2^PC_W (8'hFF wraps to 8'h00).
     - IF/ID, IF_ID_Write_En=1, Inject_Bubble=0: instr<=imem_data, pc_plus1<=PC+1 (wrapped), valid<=1.
     - IF/ID, IF_ID_Write_En=1, Inject_Bubble=1: instr<=NOP, valid<=0, pc_plus1<=PC+1.
     - IF/ID, IF_ID_Write_En=0: instr, pc_plus1 and valid hold; if_id_imm<=imem_data (immediate-byte capture for opcode 4'hC). Inject_Bubble is ignored for IF/ID; it applies downstream.
- S_VEC (one cycle): PC<=imem_data; IF/ID<=NOP, valid=0; go to S_RUN. branch_taken and Inject_Int are ignored; the control unit guarantees no taken branch is in flight during interrupt entry.
- Latency: an instruction at address A appears on if_id_instr one cycle after imem_addr=A. Redirect penalty is one fetch cycle. Interrupt entry takes 2 cycles (S_RUN->S_VEC->first ISR fetch).
- if_id_imm holds its value until the next IF_ID_Write_En=0 cycle. It is not cleared by flushes.
- Reset mid-operation (any state): immediate return to reset values and S_BOOT; the boot vector is re-read.

Test Plan:
1. Boot with M[0]=8'h10, M[0x10]=8'h21 -> release rst; cycle 1 imem_addr=0x00, PC=0x10, boot_done=1; cycle 2 if_id_instr=0x21, valid=1, pc_plus1=0x11.
2. Run from PC=0xFE with PC_Write_En=1 -> imem_addr 0xFE, 0xFF, 0x00; pc_plus1 0x00 at wrap.
3. LDM: M[0x20]=8'hC4, M[0x21]=8'h5A; drive IF_ID_Write_En=0, Inject_Bubble=1 while 0xC4 is in IF/ID -> if_id_instr stays 0xC4, if_id_imm=0x5A, PC=0x22.
4. Stall: PC_Write_En=0, IF_ID_Write_En=0 for 3 cycles at PC=0x30 -> PC and if_id_instr frozen; release -> fetch resumes at 0x30.
5. branch_taken=1, target=0x80, same cycle as Inject_Int=1 and PC_Write_En=0 -> PC=0x80, IF/ID=NOP, valid=0, state stays S_RUN, int_ret_pc unchanged.
6. Inject_Int at PC=0x42 with M[1]=8'hE0 -> int_ret_pc=0x42, imem_addr=0x01 next cycle, then PC=0xE0; IF/ID NOP throughout; next cycle if_id_instr=M[0xE0]. Assert rst mid-S_VEC -> immediate reset values, S_BOOT.
